alu64_cmd_issuer: RTL and testbench

Front-end sequencer that drives the 64-bit registered ALU's operand/opcode inputs and collects its result. Accepts one command per transaction over a valid/ready interface and holds the ALU inputs stable for the ALU's latency. Captures the ALU result and returns it, with the command tag, over a second valid/ready interface. It sits between the datapath controller and the ALU instance; it is the initiator/consumer end of the ALU's a/b/op → result interface.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu64_cmd_issuer_if.sv | 29 ++
 rtl/alu64.sv | 26 ++
 rtl/alu64_cmd_issuer.sv | 74 +++++++
 tb/tb_alu64_cmd_issuer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcode map, issuer FSM states and the
// reference evaluation used by the registered ALU.
package alu_pkg;
  localparam int DATA_W = 64;
  localparam int OP_W   = 4;
  localparam int TAG_W  = 4;

  // Only ADD is defined; 4'h1..4'hF are reserved and produce zero.
  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'h0
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } issuer_state_e;

  function automatic logic [DATA_W-1:0] alu_eval(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [OP_W-1:0]   op);
    return (op == OP_ADD) ? a + b : '0;
  endfunction
endpackage

// File: rtl/alu64_cmd_issuer_if.sv
// Command and response valid/ready channels between the datapath controller
// (master) and the ALU command issuer (slave).
interface alu64_cmd_issuer_if #(
  parameter int DATA_W = 64,
  parameter int OP_W   = 4,
  parameter int TAG_W  = 4
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [OP_W-1:0]   cmd_op;
  logic [TAG_W-1:0]  cmd_tag;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [TAG_W-1:0]  rsp_tag;
  logic [OP_W-1:0]   rsp_op;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_tag, rsp_op
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_tag, rsp_op
  );
endinterface

// File: rtl/alu64.sv
// Registered 64-bit ALU: inputs sampled each edge, result valid ALU_LAT edges later.
module alu64
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result
);
  logic [ALU_LAT-1:0][DATA_W-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= alu_eval(a, b, op);
      for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign result = pipe[ALU_LAT-1];
endmodule

// File: rtl/alu64_cmd_issuer.sv
// Single-outstanding command sequencer in front of the registered ALU: holds
// operands for the ALU latency, captures the result and returns it with its tag.
module alu64_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int OP_W    = alu_pkg::OP_W,
  parameter int TAG_W   = alu_pkg::TAG_W,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu64_cmd_issuer_if.slave    io,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output logic [OP_W-1:0]      alu_op,
  input  logic [DATA_W-1:0]    alu_result,
  output logic                 busy,
  output logic [CNT_W-1:0]     done_count
);
  localparam int LW = $clog2(ALU_LAT + 1);

  issuer_state_e    state;
  logic [LW-1:0]    wait_cnt;
  logic [TAG_W-1:0] tag_q;

  // Both decoded from state only, so no input reaches them combinationally.
  assign io.cmd_ready = (state == IDLE);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      tag_q         <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= '0;
      io.rsp_valid  <= 1'b0;
      io.rsp_result <= '0;
      io.rsp_tag    <= '0;
      io.rsp_op     <= '0;
      done_count    <= '0;
    end else begin
      case (state)
        IDLE: if (io.cmd_valid) begin
          alu_a    <= io.cmd_a;
          alu_b    <= io.cmd_b;
          alu_op   <= io.cmd_op;
          tag_q    <= io.cmd_tag;
          wait_cnt <= LW'(ALU_LAT);
          state    <= WAIT;
        end
        // One extra edge past ALU_LAT: the ALU samples alu_* on the edge after issue.
        WAIT: if (wait_cnt == '0) begin
          io.rsp_result <= alu_result;
          io.rsp_tag    <= tag_q;
          io.rsp_op     <= alu_op;
          io.rsp_valid  <= 1'b1;
          state         <= RESP;
        end else begin
          wait_cnt <= wait_cnt - 1'b1;
        end
        RESP: if (io.rsp_ready) begin
          io.rsp_valid <= 1'b0;
          done_count   <= done_count + 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu64_cmd_issuer.sv
// Randomized bench for alu64_cmd_issuer with the registered ALU beside it,
// checked against a transaction-level model (a+b for ADD, zero otherwise).
module tb_alu64_cmd_issuer;
  localparam int ALU_LAT = 1;
  localparam int CNT_W   = 10;
  localparam int WRAP    = 1 << CNT_W;

  logic clk, rst_n;
  logic [63:0]      alu_a, alu_b, alu_result;
  logic [3:0]       alu_op;
  logic             busy;
  logic [CNT_W-1:0] done_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  alu64_cmd_issuer_if #(.DATA_W(64), .OP_W(4), .TAG_W(4)) io ();

  alu64_cmd_issuer #(.ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .io(io),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .busy(busy), .done_count(done_count)
  );

  alu64 #(.ALU_LAT(ALU_LAT)) u_alu (
    .clk(clk), .rst_n(rst_n), .a(alu_a), .b(alu_b), .op(alu_op), .result(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [3:0] op);
    return (op == 4'h0) ? a + b : 64'h0;
  endfunction

  // One full transaction. With hold_next, a second command is left asserted
  // after acceptance so that it must be ignored until the response completes.
  task automatic run_cmd(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                         input logic [3:0] tag, input int stall, input bit early_rdy,
                         input bit hold_next, input logic [63:0] na, output int waited);
    logic [63:0] exp_r;
    int n;
    exp_r = model(a, b, op);
    io.cmd_a = a; io.cmd_b = b; io.cmd_op = op; io.cmd_tag = tag; io.cmd_valid = 1'b1;
    waited = 0;
    while (!io.cmd_ready && waited < 50) begin tick(); waited++; end
    tick();
    if (hold_next) begin
      io.cmd_a = na; io.cmd_b = ~na; io.cmd_op = 4'h0; io.cmd_tag = tag + 4'h1;
    end else begin
      io.cmd_valid = 1'b0;
    end
    chk("issue_a", alu_a, a);
    chk("issue_b", alu_b, b);
    chk("issue_op", 64'(alu_op), 64'(op));
    chk("busy_wait", 64'(busy), 64'd1);
    chk("rdy_wait", 64'(io.cmd_ready), 64'd0);
    io.rsp_ready = early_rdy;
    n = 0;
    while (!io.rsp_valid && n < 50) begin
      tick(); n++;
      chk("hold_a", alu_a, a);
    end
    chk("rsp_lat", 64'(n), 64'(ALU_LAT + 1));
    chk("rsp_result", io.rsp_result, exp_r);
    chk("rsp_tag", 64'(io.rsp_tag), 64'(tag));
    chk("rsp_op", 64'(io.rsp_op), 64'(op));
    io.rsp_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("bp_valid", 64'(io.rsp_valid), 64'd1);
      chk("bp_result", io.rsp_result, exp_r);
      chk("bp_tag", 64'(io.rsp_tag), 64'(tag));
      chk("bp_op", 64'(io.rsp_op), 64'(op));
      chk("bp_rdy", 64'(io.cmd_ready), 64'd0);
      chk("bp_alu_a", alu_a, a);
    end
    io.rsp_ready = 1'b1;
    tick();
    io.rsp_ready = 1'b0;
    exp_cnt++;
    chk("post_valid", 64'(io.rsp_valid), 64'd0);
    chk("done_count", 64'(done_count), 64'(exp_cnt % WRAP));
    chk("post_rdy", 64'(io.cmd_ready), 64'd1);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_alu_a", alu_a, a);
  endtask

  initial begin
    int w;
    logic [63:0] ra, rb;
    logic [3:0]  rop;
    rst_n = 1'b0;
    io.cmd_valid = 1'b0; io.cmd_a = '0; io.cmd_b = '0; io.cmd_op = '0; io.cmd_tag = '0;
    io.rsp_ready = 1'b0;
    #3;
    chk("rst_valid", 64'(io.rsp_valid), 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_result", io.rsp_result, 64'd0);
    chk("rst_cnt", 64'(done_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_rdy", 64'(io.cmd_ready), 64'd1);

    // Directed cases
    run_cmd(64'd5, 64'd7, 4'h0, 4'h3, 0, 1'b0, 1'b0, 64'd0, w);
    chk("basic_cnt", 64'(done_count), 64'd1);
    run_cmd(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'h0, 4'h1, 0, 1'b0, 1'b0, 64'd0, w);
    run_cmd(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'h0, 4'h2, 1, 1'b0, 1'b0, 64'd0, w);
    run_cmd(64'd9, 64'd9, 4'hA, 4'hF, 0, 1'b0, 1'b0, 64'd0, w);
    run_cmd(64'h1234, 64'h4321, 4'h0, 4'h6, 5, 1'b1, 1'b1, 64'h55, w);
    run_cmd(64'h55, ~64'h55, 4'h0, 4'h7, 0, 1'b0, 1'b0, 64'd0, w);
    chk("bp_accept_wait", 64'(w), 64'd0);

    // Reset one cycle into WAIT discards the transaction
    io.cmd_a = 64'd100; io.cmd_b = 64'd200; io.cmd_op = 4'h0; io.cmd_tag = 4'h9;
    io.cmd_valid = 1'b1;
    tick();
    io.cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("mid_rst_valid", 64'(io.rsp_valid), 64'd0);
    chk("mid_rst_alu_a", alu_a, 64'd0);
    chk("mid_rst_alu_b", alu_b, 64'd0);
    chk("mid_rst_alu_op", 64'(alu_op), 64'd0);
    chk("mid_rst_cnt", 64'(done_count), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_rdy", 64'(io.cmd_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_stale_rsp", 64'(io.rsp_valid), 64'd0);
    end

    // Random traffic, then keep going back-to-back until the counter wraps
    for (int i = 0; i < 200; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      rop = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      run_cmd(ra, rb, rop, 4'($urandom), $urandom_range(0, 3), 1'($urandom),
              1'b0, 64'd0, w);
    end
    while (exp_cnt < WRAP + 2) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      run_cmd(ra, rb, 4'h0, 4'($urandom), 0, 1'b0, 1'b0, 64'd0, w);
      if (exp_cnt == WRAP) chk("cnt_wrap", 64'(done_count), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
